// File: rtl/drive_mode_ctrl.sv
// Vehicle mode controller: OFF/PARK/DRIVE/REVERSE selected by edge-detected buttons,
// with rest-gated gear changes out of moving modes and an optional PARK idle timeout.
module drive_mode_ctrl #(
  parameter int unsigned XW            = 2,
  parameter int unsigned YW            = 7,
  parameter int unsigned X_REST        = 0,
  parameter int unsigned Y_REST        = 27,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned IDLE_CYCLES   = 0
) (
  input  logic          clock_50,
  input  logic          reset,
  input  logic          parkButton,
  input  logic          driveButton,
  input  logic          reverseButton,
  input  logic [XW-1:0] x_speed,
  input  logic [YW-1:0] y_speed,
  output logic          parkEnable,
  output logic          driveEnable,
  output logic          reverseEnable,
  output logic [1:0]    mode,
  output logic          atRest,
  output logic          rejected
);

  localparam int unsigned    RW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [RW-1:0]  SETTLE    = RW'(SETTLE_CYCLES);
  localparam int unsigned    IW        = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [IW-1:0]  IDLE_LAST = IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [XW-1:0]  XR        = XW'(X_REST);
  localparam logic [YW-1:0]  YR        = YW'(Y_REST);

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_PARK    = 2'b01,
    S_DRIVE   = 2'b10,
    S_REVERSE = 2'b11
  } state_t;

  state_t        state, next_state;
  logic          park_q, drive_q, reverse_q;
  logic          pe, de, re, any_edge;
  logic [RW-1:0] rest_cnt;
  logic [IW-1:0] idle_cnt;
  logic          rest_now, idle_expire, reject_c;

  assign pe       = parkButton & ~park_q;
  assign de       = driveButton & ~drive_q;
  assign re       = reverseButton & ~reverse_q;
  assign any_edge = pe | de | re;
  assign rest_now = (x_speed == XR) && (y_speed == YR);
  assign atRest   = (rest_cnt == SETTLE);

  // History resets high so a button held through reset must be released first.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      park_q    <= 1'b1;
      drive_q   <= 1'b1;
      reverse_q <= 1'b1;
    end else begin
      park_q    <= parkButton;
      drive_q   <= driveButton;
      reverse_q <= reverseButton;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset || !rest_now)
      rest_cnt <= '0;
    else if (rest_cnt != SETTLE)
      rest_cnt <= rest_cnt + RW'(1);
  end

  always_ff @(posedge clock_50) begin
    if (reset || state != S_PARK || any_edge)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + IW'(1);
  end

  assign idle_expire = (IDLE_CYCLES > 0) && (state == S_PARK) &&
                       (idle_cnt == IDLE_LAST) && !any_edge;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state    <= S_OFF;
      rejected <= 1'b0;
    end else begin
      state    <= next_state;
      rejected <= reject_c;
    end
  end

  always_comb begin
    next_state = state;
    reject_c   = 1'b0;
    case (state)
      S_OFF: begin
        if (pe)             next_state = S_PARK;
        else if (de || re)  reject_c   = 1'b1;
      end
      S_PARK: begin
        if (de && re)       reject_c   = 1'b1;
        else if (de)        next_state = S_DRIVE;
        else if (re)        next_state = S_REVERSE;
        else if (idle_expire) next_state = S_OFF;
      end
      S_DRIVE: begin
        if (pe && atRest)       next_state = S_PARK;
        else if (re && atRest)  next_state = S_REVERSE;
        else if (pe || re)      reject_c   = 1'b1;
      end
      S_REVERSE: begin
        if (pe && atRest)       next_state = S_PARK;
        else if (de && atRest)  next_state = S_DRIVE;
        else if (pe || de)      reject_c   = 1'b1;
      end
      default: next_state = S_OFF;
    endcase
  end

  always_comb begin
    parkEnable    = 1'b0;
    driveEnable   = 1'b0;
    reverseEnable = 1'b0;
    mode          = 2'b00;
    case (state)
      S_PARK:    begin parkEnable    = 1'b1; mode = 2'b01; end
      S_DRIVE:   begin driveEnable   = 1'b1; mode = 2'b10; end
      S_REVERSE: begin reverseEnable = 1'b1; mode = 2'b11; end
      default:   ;
    endcase
  end

endmodule
